pi_out_limiter: RTL

Downstream stage of the PI controller. It takes the raw signed 32-bit PI output and produces the actuation command for the resonant-converter modulator.
- Clamps the command to [MIN_OUT, MAX_OUT].
- Applies a soft-start ramp after enable, and an optional slew limit once running.
- Returns the excess (raw minus applied) as the anti-windup term, which feeds the PI block's aw input.

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/pi_out_limiter_step_toward.sv | 45 ++++
 rtl/pi_out_limiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the PI output stage:
//   CTRL_W              - data path width of commands and PI samples
//   ST_IDLE/ST_RAMP/ST_RUN - limiter state encoding (also driven out on o_state)
//   sat_to_w()          - saturates a CTRL_W+1 bit signed value into CTRL_W bits
// ----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int CTRL_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // The two top bits disagree only when the value does not fit in CTRL_W
    // bits; the sign bit then tells which rail to pin to.
    function automatic logic signed [CTRL_W-1:0] sat_to_w(input logic signed [CTRL_W:0] v);
        logic signed [CTRL_W-1:0] r;
        if (v[CTRL_W] != v[CTRL_W-1]) begin
            r = v[CTRL_W] ? {1'b1, {(CTRL_W-1){1'b0}}} : {1'b0, {(CTRL_W-1){1'b1}}};
        end else begin
            r = v[CTRL_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pi_out_limiter_step_toward.sv
// ----------------------------------------------------------------------------
// step_toward
// Combinational rate limiter: moves x toward tgt by at most s per call.
//   x       in  CTRL_W  signed current value
//   tgt     in  CTRL_W  signed target value
//   s       in  CTRL_W  signed maximum step (> 0)
//   nxt     out CTRL_W  signed next value (tgt when within reach, else x +/- s)
//   limited out 1       high when the step size cut the move short
// The difference is formed one bit wider so opposite-rail operands never wrap.
// ----------------------------------------------------------------------------
module step_toward
    import ctrl_pkg::*;
(
    input  logic signed [CTRL_W-1:0] x,
    input  logic signed [CTRL_W-1:0] tgt,
    input  logic signed [CTRL_W-1:0] s,
    output logic signed [CTRL_W-1:0] nxt,
    output logic                     limited
);

    logic signed [CTRL_W:0] x_ext;
    logic signed [CTRL_W:0] s_ext;
    logic signed [CTRL_W:0] diff;
    logic signed [CTRL_W:0] sum_up;
    logic signed [CTRL_W:0] sum_dn;

    always_comb begin
        x_ext   = {x[CTRL_W-1], x};
        s_ext   = {s[CTRL_W-1], s};
        diff    = {tgt[CTRL_W-1], tgt} - x_ext;
        sum_up  = x_ext + s_ext;
        sum_dn  = x_ext - s_ext;
        nxt     = tgt;
        limited = 1'b0;
        // x +/- s only taken when strictly short of tgt, so it stays in range.
        if (diff > s_ext) begin
            nxt     = sum_up[CTRL_W-1:0];
            limited = 1'b1;
        end else if (diff < -s_ext) begin
            nxt     = sum_dn[CTRL_W-1:0];
            limited = 1'b1;
        end
    end

endmodule

// File: rtl/pi_out_limiter.sv
// ----------------------------------------------------------------------------
// pi_out_limiter
// Converts the raw PI output into the modulator command: clamp to
// [MIN_OUT, MAX_OUT], soft-start ramp after enable, and return the excess as
// the anti-windup term for the PI block.
// Optional feature macro: PI_OUT_SLEW_EN - when defined, RUN also rate-limits
// the command by SLEW_MAX per sample; otherwise RUN passes the clamped target.
// Ports:
//   i_CLK    in   1   clock
//   i_RST    in   1   asynchronous active-low reset
//   i_EN     in   1   converter enable (level); low forces IDLE
//   i_valid  in   1   i_PI carries a new sample
//   i_PI     in   32  signed raw PI output
//   o_CMD    out  32  signed applied command
//   o_valid  out  1   one-cycle strobe, o_CMD/o_AW just updated
//   o_AW     out  32  signed anti-windup term i_PI - o_CMD (saturated)
//   o_sat    out  1   sample altered by clamp or step limit
//   o_state  out  2   0 IDLE, 1 RAMP, 2 RUN
// ----------------------------------------------------------------------------
module pi_out_limiter
    import ctrl_pkg::*;
#(
    parameter logic signed [CTRL_W-1:0] MIN_OUT   = -32'sd1000,
    parameter logic signed [CTRL_W-1:0] MAX_OUT   = 32'sd1000,
    parameter logic signed [CTRL_W-1:0] RESET_OUT = 32'sd0,
    parameter logic signed [CTRL_W-1:0] SS_STEP   = 32'sd1,
    parameter logic signed [CTRL_W-1:0] SLEW_MAX  = 32'sd16
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_EN,
    input  logic                     i_valid,
    input  logic signed [CTRL_W-1:0] i_PI,
    output logic signed [CTRL_W-1:0] o_CMD,
    output logic                     o_valid,
    output logic signed [CTRL_W-1:0] o_AW,
    output logic                     o_sat,
    output logic [1:0]               o_state
);

    logic [1:0]               state_q, state_d;
    logic signed [CTRL_W-1:0] cmd_q, cmd_d;
    logic signed [CTRL_W-1:0] aw_q, aw_d;
    logic                     sat_q, sat_d;
    logic                     valid_q, valid_d;

    logic signed [CTRL_W-1:0] tgt;
    logic                     clamped;
    logic signed [CTRL_W-1:0] step_s;
    logic signed [CTRL_W-1:0] step_nxt;
    logic                     step_lim;
    logic signed [CTRL_W-1:0] new_cmd;
    logic                     new_sat;
    logic signed [CTRL_W:0]   aw_raw;

    // Target is the raw sample pinned into the command window.
    always_comb begin
        tgt     = i_PI;
        clamped = 1'b0;
        if (i_PI > MAX_OUT) begin
            tgt     = MAX_OUT;
            clamped = 1'b1;
        end else if (i_PI < MIN_OUT) begin
            tgt     = MIN_OUT;
            clamped = 1'b1;
        end
    end

    // One limiter shared by RAMP and RUN; only the step size differs.
`ifdef PI_OUT_SLEW_EN
    assign step_s = (state_q == ST_RAMP) ? SS_STEP : SLEW_MAX;
`else
    assign step_s = SS_STEP;
`endif

    step_toward u_step (
        .x       (cmd_q),
        .tgt     (tgt),
        .s       (step_s),
        .nxt     (step_nxt),
        .limited (step_lim)
    );

    // Command a valid sample would apply. A clamped sample can never equal
    // i_PI, and an unclamped one differs from it only when step-limited, so
    // clamped|limited is exactly "new command != i_PI".
    always_comb begin
        new_cmd = step_nxt;
        new_sat = clamped | step_lim;
`ifndef PI_OUT_SLEW_EN
        if (state_q == ST_RUN) begin
            new_cmd = tgt;
            new_sat = clamped;
        end
`endif
        aw_raw = {i_PI[CTRL_W-1], i_PI} - {new_cmd[CTRL_W-1], new_cmd};
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        aw_d    = aw_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        if (!i_EN) begin
            state_d = ST_IDLE;
            cmd_d   = RESET_OUT;
            aw_d    = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                // A sample arriving with the enable edge is dropped.
                ST_IDLE: state_d = ST_RAMP;
                ST_RAMP, ST_RUN: begin
                    if (i_valid) begin
                        valid_d = 1'b1;
                        cmd_d   = new_cmd;
                        aw_d    = sat_to_w(aw_raw);
                        sat_d   = new_sat;
                        if (state_q == ST_RAMP && new_cmd == tgt) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cmd_d   = RESET_OUT;
                    aw_d    = '0;
                    sat_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= ST_IDLE;
            cmd_q   <= RESET_OUT;
            aw_q    <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            aw_q    <= aw_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign o_CMD   = cmd_q;
    assign o_AW    = aw_q;
    assign o_sat   = sat_q;
    assign o_valid = valid_q;
    assign o_state = state_q;

endmodule
